sqrt_stream: RTL and testbench
==============================

SQRT_STREAM -- requirements
Module: sqrt_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32: radicand, root and remainder width in bits.
REQ-002 SHALL have parameter FBITS, default 16: fractional bits of the unsigned Q(WIDTH-FBITS).FBITS format.
REQ-003 SHALL have parameter STEPS, default 1: root bits resolved per clock; ITER=(WIDTH+FBITS)/2; ITER mod STEPS = 0; C=ITER/STEPS.
REQ-004 SHALL have parameter SIGNED, default 0: 1 means rad is two's complement and negative input is an error.
REQ-005 SHALL have parameter TAG_W, default 4: width of the sideband tag.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1, request present.
REQ-009 SHALL have port in_ready, output, 1, block can accept a request.
REQ-010 SHALL have port rad, input, WIDTH, radicand.
REQ-011 SHALL have port round_en, input, 1, 1 means round root to nearest.
REQ-012 SHALL have port in_tag, input, TAG_W, sideband tag.
REQ-013 SHALL have port out_valid, output, 1, result present.
REQ-014 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-015 SHALL have port root, output, WIDTH, result with FBITS fractional bits, zero-extended.
REQ-016 SHALL have port rem, output, WIDTH, remainder of the truncated root, zero-extended.
REQ-017 SHALL have port err, output, 1, negative radicand (SIGNED=1 only).
REQ-018 SHALL have port out_tag, output, TAG_W, tag of the request that produced the result.

Function
REQ-019 SHALL implement the states IDLE, CALC and DONE.
REQ-020 SHALL accept a request on a rising edge where in_valid and in_ready are both 1, and SHALL register rad, round_en and in_tag on that edge.
REQ-021 SHALL drive in_ready as 1 in IDLE, 1 in DONE while out_ready is 1, and 0 in CALC.
REQ-022 SHALL compute the restoring digit-by-digit square root of R=rad<<FBITS, an (WIDTH+FBITS)-bit value: root_t=floor(sqrt(R)), rem=R-root_t^2.
REQ-023 SHALL resolve exactly STEPS root bits per CALC cycle, MSB first, and SHALL enter DONE after C CALC edges, so out_valid first reads 1 in the cycle following the C-th edge after acceptance (latency C).
REQ-024 SHALL drive root=root_t+1 when round_en=1 and rem>root_t, else root=root_t; rem SHALL always report the truncated remainder.
REQ-025 SHALL, when SIGNED=1 and rad[WIDTH-1]=1, skip CALC, enter DONE on the edge after acceptance, and drive err=1, root=0, rem=0.
REQ-026 SHALL drive err=0 whenever SIGNED=0.
REQ-027 SHALL hold out_valid, root, rem, err and out_tag stable in DONE until out_ready=1.
REQ-028 SHALL return DONE to IDLE when out_ready=1 and in_valid=0.
REQ-029 SHALL go from DONE directly to CALC when out_ready=1 and in_valid=1, consuming the old result and accepting the new request on the same edge, with no bubble.
REQ-030 SHALL produce root=0, rem=0 for rad=0 with normal latency.
REQ-031 SHALL treat rad values at maximum (all ones, SIGNED=0) without overflow; the internal remainder SHALL be ITER+2 bits wide.

Reset
REQ-032 SHALL, on an edge with rst_n=0, enter IDLE and set out_valid=0, in_ready=1 after reset, root=0, rem=0, err=0 and out_tag=0.
REQ-033 SHALL make reset take precedence over all handshakes; an in-flight computation SHALL be discarded and no result emitted.

Verification (WIDTH=32, FBITS=16, STEPS=1 unless noted)
REQ-034 The bench SHALL check: rad=0x00020000, round_en=0 -> root=0x00016A09, rem=0x00028BAF, out_valid after exactly 24 cycles; with round_en=1 -> root=0x00016A0A.
REQ-035 The bench SHALL check: rad=0x00040000 -> root=0x00020000, rem=0; rad=0x00900000 -> root=0x000C0000, rem=0; rad=0x00002000, round_en=1 -> root=0x00005A82, rem=0x000055FC.
REQ-036 The bench SHALL check back-to-back operation: in_valid held high with out_ready=1 and tags 1,2,3 -> three results in tag order, spaced 25 cycles apart, with no DONE->IDLE bubble.
REQ-037 The bench SHALL check backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0; the result is consumed on the first out_ready=1 edge.
REQ-038 The bench SHALL check SIGNED=1: rad=0xFFFF0000 -> err=1, root=0, rem=0, out_valid one cycle after acceptance.
REQ-039 The bench SHALL check STEPS=4: rad=0x00020000 -> root=0x00016A09 after 6 cycles; and rst_n=0 at cycle 10 of a computation -> no out_valid, in_ready=1 after reset.

Source files
------------

// File: rtl/sqrt_stream.sv
// Streaming restoring square root of rad<<FBITS with valid/ready handshakes.
// Resolves STEPS root bits per cycle; optional round-to-nearest and signed-error detection.
module sqrt_stream #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned FBITS  = 16,
    parameter int unsigned STEPS  = 1,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rad,
    input  logic             round_en,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] root,
    output logic [WIDTH-1:0] rem,
    output logic             err,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned ITER = (WIDTH + FBITS) / 2;
    localparam int unsigned C    = ITER / STEPS;
    localparam int unsigned RW   = 2 * ITER;
    localparam int unsigned REMW = ITER + 2;
    localparam int unsigned CW   = $clog2(C + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [RW-1:0]    r_rad;
    logic [REMW-1:0]  r_rem;
    logic [ITER-1:0]  r_root;
    logic             r_round;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] r_out_root;
    logic [WIDTH-1:0] r_out_rem;
    logic             r_err;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_accept;
    logic             w_neg;
    logic [RW-1:0]    w_rad;
    logic [REMW-1:0]  w_rem;
    logic [ITER-1:0]  w_root;
    logic [REMW+1:0]  w_acc;
    logic [REMW+1:0]  w_trial;
    logic [ITER:0]    w_root_fin;

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_neg     = (SIGNED != 0) && rad[WIDTH-1];
    assign out_valid = (r_state == DONE);
    assign root      = r_out_root;
    assign rem       = r_out_rem;
    assign err       = r_err;
    assign out_tag   = r_out_tag;

    // STEPS restoring iterations unrolled; each consumes two radicand bits MSB first.
    always_comb begin
        w_rad   = r_rad;
        w_rem   = r_rem;
        w_root  = r_root;
        w_acc   = '0;
        w_trial = '0;
        for (int unsigned s = 0; s < STEPS; s++) begin
            w_acc   = {w_rem, w_rad[RW-1 -: 2]};
            w_trial = {2'b00, w_root, 2'b01};
            if (w_acc >= w_trial) begin
                w_rem  = REMW'(w_acc - w_trial);
                w_root = {w_root[ITER-2:0], 1'b1};
            end else begin
                w_rem  = REMW'(w_acc);
                w_root = {w_root[ITER-2:0], 1'b0};
            end
            w_rad = {w_rad[RW-3:0], 2'b00};
        end
        if (r_round && (w_rem > REMW'(w_root)))
            w_root_fin = {1'b0, w_root} + (ITER+1)'(1);
        else
            w_root_fin = {1'b0, w_root};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rad      <= '0;
            r_rem      <= '0;
            r_root     <= '0;
            r_round    <= 1'b0;
            r_tag      <= '0;
            r_out_root <= '0;
            r_out_rem  <= '0;
            r_err      <= 1'b0;
            r_out_tag  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if ((r_state == DONE) && out_ready && !in_valid)
                        r_state <= IDLE;
                    if (w_accept) begin
                        r_rad   <= RW'(rad) << FBITS;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_cnt   <= '0;
                        r_round <= round_en;
                        r_tag   <= in_tag;
                        if (w_neg) begin
                            r_state    <= DONE;
                            r_out_root <= '0;
                            r_out_rem  <= '0;
                            r_err      <= 1'b1;
                            r_out_tag  <= in_tag;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rad  <= w_rad;
                    r_rem  <= w_rem;
                    r_root <= w_root;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(C - 1)) begin
                        r_state    <= DONE;
                        r_out_root <= WIDTH'(w_root_fin);
                        r_out_rem  <= WIDTH'(w_rem);
                        r_err      <= 1'b0;
                        r_out_tag  <= r_tag;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_stream.sv
// Directed bench for sqrt_stream: default, SIGNED=1 and STEPS=4 instances on one clock.
module tb_sqrt_stream;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic        a_in_valid, a_in_ready, a_round, a_out_valid, a_out_ready, a_err;
    logic [31:0] a_rad, a_root, a_rem;
    logic [3:0]  a_in_tag, a_out_tag;
    logic        b_in_valid, b_in_ready, b_round, b_out_valid, b_out_ready, b_err;
    logic [31:0] b_rad, b_root, b_rem;
    logic [3:0]  b_in_tag, b_out_tag;
    logic        c_in_valid, c_in_ready, c_round, c_out_valid, c_out_ready, c_err;
    logic [31:0] c_rad, c_root, c_rem;
    logic [3:0]  c_in_tag, c_out_tag;

    sqrt_stream #(.WIDTH(32), .FBITS(16), .STEPS(1), .SIGNED(0), .TAG_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .rad(a_rad), .round_en(a_round), .in_tag(a_in_tag), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .root(a_root), .rem(a_rem), .err(a_err), .out_tag(a_out_tag)
    );
    sqrt_stream #(.WIDTH(32), .FBITS(16), .STEPS(1), .SIGNED(1), .TAG_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .rad(b_rad), .round_en(b_round), .in_tag(b_in_tag), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .root(b_root), .rem(b_rem), .err(b_err), .out_tag(b_out_tag)
    );
    sqrt_stream #(.WIDTH(32), .FBITS(16), .STEPS(4), .SIGNED(0), .TAG_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .rad(c_rad), .round_en(c_round), .in_tag(c_in_tag), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .root(c_root), .rem(c_rem), .err(c_err), .out_tag(c_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request for a single cycle; acceptance happens on the edge inside.
    task automatic send(input int which, input logic [31:0] r, input logic rnd, input logic [3:0] t);
        case (which)
            0: begin a_in_valid = 1'b1; a_rad = r; a_round = rnd; a_in_tag = t; end
            1: begin b_in_valid = 1'b1; b_rad = r; b_round = rnd; b_in_tag = t; end
            default: begin c_in_valid = 1'b1; c_rad = r; c_round = rnd; c_in_tag = t; end
        endcase
        tick();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        c_in_valid = 1'b0;
    endtask

    // Counts edges until out_valid reads 1, bounded.
    task automatic wait_valid(input int which, output int n);
        logic v;
        n = 0;
        do begin
            tick();
            n++;
            case (which)
                0: v = a_out_valid;
                1: v = b_out_valid;
                default: v = c_out_valid;
            endcase
        end while (!v && n < 200);
    endtask

    task automatic run_a(input string name, input logic [31:0] r, input logic rnd,
                         input logic [31:0] exp_root, input logic [31:0] exp_rem);
        int n;
        send(0, r, rnd, 4'h5);
        wait_valid(0, n);
        check({name, "_lat"}, 32'(n), 32'd24);
        check({name, "_root"}, a_root, exp_root);
        check({name, "_rem"}, a_rem, exp_rem);
        check({name, "_tag"}, 32'(a_out_tag), 32'h5);
        check({name, "_err"}, 32'(a_err), 32'h0);
        tick();
    endtask

    initial begin
        int n;
        logic [31:0] held_root;
        logic [31:0] held_rem;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_rad = '0; a_round = 1'b0; a_in_tag = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_rad = '0; b_round = 1'b0; b_in_tag = '0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_rad = '0; c_round = 1'b0; c_in_tag = '0; c_out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(a_out_valid), 32'h0);
        check("rst_in_ready", 32'(a_in_ready), 32'h1);
        check("rst_root", a_root, 32'h0);
        check("rst_rem", a_rem, 32'h0);
        check("rst_err", 32'(a_err), 32'h0);
        check("rst_tag", 32'(a_out_tag), 32'h0);
        rst_n = 1'b1;
        tick();

        run_a("sqrt2", 32'h0002_0000, 1'b0, 32'h0001_6A09, 32'h0002_8BAF);
        run_a("sqrt2_rnd", 32'h0002_0000, 1'b1, 32'h0001_6A0A, 32'h0002_8BAF);
        run_a("sqrt4", 32'h0004_0000, 1'b0, 32'h0002_0000, 32'h0);
        run_a("sqrt144", 32'h0090_0000, 1'b0, 32'h000C_0000, 32'h0);
        run_a("sqrt8th", 32'h0000_2000, 1'b1, 32'h0000_5A82, 32'h0000_55FC);
        run_a("zero", 32'h0, 1'b0, 32'h0, 32'h0);
        run_a("max", 32'hFFFF_FFFF, 1'b0, 32'h00FF_FFFF, 32'h01FE_FFFF);
        run_a("max_rnd", 32'hFFFF_FFFF, 1'b1, 32'h0100_0000, 32'h01FE_FFFF);

        // Back-to-back: in_valid held high, results every 25 cycles with no idle bubble.
        a_in_valid = 1'b1; a_rad = 32'h0004_0000; a_round = 1'b0; a_in_tag = 4'h1;
        tick();
        a_rad = 32'h0090_0000; a_in_tag = 4'h2;
        wait_valid(0, n);
        check("b2b_lat1", 32'(n), 32'd24);
        check("b2b_tag1", 32'(a_out_tag), 32'h1);
        check("b2b_root1", a_root, 32'h0002_0000);
        tick();
        check("b2b_nobubble_rdy", 32'(a_in_ready), 32'h0);
        check("b2b_nobubble_vld", 32'(a_out_valid), 32'h0);
        a_rad = 32'h0002_0000; a_in_tag = 4'h3;
        wait_valid(0, n);
        check("b2b_gap2", 32'(n + 1), 32'd25);
        check("b2b_tag2", 32'(a_out_tag), 32'h2);
        check("b2b_root2", a_root, 32'h000C_0000);
        tick();
        a_in_valid = 1'b0;
        check("b2b_nobubble2", 32'(a_in_ready), 32'h0);
        wait_valid(0, n);
        check("b2b_gap3", 32'(n + 1), 32'd25);
        check("b2b_tag3", 32'(a_out_tag), 32'h3);
        check("b2b_root3", a_root, 32'h0001_6A09);
        tick();
        check("b2b_idle", 32'(a_in_ready), 32'h1);

        // Backpressure: result held for 10 cycles, a pending request must not be taken.
        a_out_ready = 1'b0;
        send(0, 32'h0090_0000, 1'b0, 4'h7);
        wait_valid(0, n);
        held_root = a_root;
        held_rem = a_rem;
        check("bp_root", held_root, 32'h000C_0000);
        a_in_valid = 1'b1; a_rad = 32'h0004_0000; a_in_tag = 4'h8;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 32'(a_out_valid), 32'h1);
            check("bp_root_hold", a_root, held_root);
            check("bp_rem_hold", a_rem, held_rem);
            check("bp_tag_hold", 32'(a_out_tag), 32'h7);
            check("bp_in_ready", 32'(a_in_ready), 32'h0);
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        check("bp_consumed", 32'(a_out_valid), 32'h0);
        check("bp_idle", 32'(a_in_ready), 32'h1);

        // Signed instance: negative radicand errors out one cycle after acceptance.
        send(1, 32'hFFFF_0000, 1'b0, 4'h9);
        check("neg_lat", 32'(b_out_valid), 32'h1);
        check("neg_err", 32'(b_err), 32'h1);
        check("neg_root", b_root, 32'h0);
        check("neg_rem", b_rem, 32'h0);
        check("neg_tag", 32'(b_out_tag), 32'h9);
        tick();
        send(1, 32'h0004_0000, 1'b0, 4'hA);
        wait_valid(1, n);
        check("spos_lat", 32'(n), 32'd24);
        check("spos_root", b_root, 32'h0002_0000);
        check("spos_err", 32'(b_err), 32'h0);
        tick();

        // Four bits per cycle: six-cycle latency.
        send(2, 32'h0002_0000, 1'b0, 4'hB);
        wait_valid(2, n);
        check("s4_lat", 32'(n), 32'd6);
        check("s4_root", c_root, 32'h0001_6A09);
        check("s4_rem", c_rem, 32'h0002_8BAF);
        check("s4_tag", 32'(c_out_tag), 32'hB);
        tick();

        // Reset at cycle 10 of a computation discards it.
        send(0, 32'h0002_0000, 1'b0, 4'hC);
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(a_out_valid), 32'h0);
        check("mid_rst_ready", 32'(a_in_ready), 32'h1);
        check("mid_rst_tag", 32'(a_out_tag), 32'h0);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (a_out_valid) n++;
        end
        check("mid_rst_no_result", 32'(n), 32'h0);
        check("mid_rst_ready2", 32'(a_in_ready), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
